// File: rtl/gpio_irq_filter.sv
// gpio_irq_filter: pad synchroniser, per-pin debounce and latched edge interrupts on the simple memory bus
module gpio_irq_filter #(
  parameter int TOTAL_GPIOS = 8,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                   mem_clk,
  input  logic                   rst_n,
  input  logic                   mem_valid,
  input  logic [3:0]             mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic [3:0]             mem_wstrb,
  input  logic [TOTAL_GPIOS-1:0] pad_in,
  output logic [TOTAL_GPIOS-1:0] gpio_filt,
  output logic                   irq,
  output logic                   mem_ready,
  output logic [31:0]            mem_rdata
);
  localparam int N = TOTAL_GPIOS;
  logic [N-1:0] rer, fer, isfr, dben, s1, s2, filt, prev, clr, rise, fall;
  logic [N-1:0][2:0] hist;
  logic [DIV_WIDTH-1:0] dbdiv, cnt;
  logic wr, tick, unused_wdata;
  assign unused_wdata = ^mem_wdata;
  assign wr = mem_valid && &mem_wstrb;
  assign tick = cnt == dbdiv;
  assign clr = (wr && mem_addr == 4'd2) ? mem_wdata[N-1:0] : '0;
  assign rise = filt & ~prev;
  assign fall = ~filt & prev;
  assign gpio_filt = filt;
  assign irq = |isfr;
  assign mem_ready = mem_valid;
  always_ff @(posedge mem_clk or negedge rst_n)
    if (!rst_n) begin
      rer <= '0;
      fer <= '0;
      isfr <= '0;
      dben <= '0;
      dbdiv <= '0;
      cnt <= '0;
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      prev <= '0;
      hist <= '0;
    end else begin
      s1 <= pad_in;
      s2 <= s1;
      prev <= filt;
      // a new edge outranks a simultaneous software clear
      isfr <= (isfr & ~clr) | (rise & rer) | (fall & fer);
      cnt <= ((wr && mem_addr == 4'd3) || tick) ? '0 : cnt + 1'b1;
      if (wr && mem_addr == 4'd0) rer <= mem_wdata[N-1:0];
      if (wr && mem_addr == 4'd1) fer <= mem_wdata[N-1:0];
      if (wr && mem_addr == 4'd3) dbdiv <= mem_wdata[DIV_WIDTH-1:0];
      if (wr && mem_addr == 4'd4) dben <= mem_wdata[N-1:0];
      for (int i = 0; i < N; i++)
        if (!dben[i]) filt[i] <= s2[i];
        else if (tick) begin
          hist[i] <= {hist[i][1:0], s2[i]};
          if (hist[i][1:0] == {2{s2[i]}} && filt[i] != s2[i]) filt[i] <= s2[i];
        end
    end
  always_comb begin
    mem_rdata = '0;
    if (mem_valid)
      case (mem_addr)
        4'd0: mem_rdata[N-1:0] = rer;
        4'd1: mem_rdata[N-1:0] = fer;
        4'd2: mem_rdata[N-1:0] = isfr;
        4'd3: mem_rdata[DIV_WIDTH-1:0] = dbdiv;
        4'd4: mem_rdata[N-1:0] = dben;
        4'd5: mem_rdata[N-1:0] = filt;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_gpio_irq_filter.sv
// tb_gpio_irq_filter: directed bench for sync latency, debounce, edge flags, W1C and async reset
module tb_gpio_irq_filter;
  logic mem_clk = 0, rst_n = 0, mem_valid = 0, irq, mem_ready;
  logic [3:0] mem_addr = 0, mem_wstrb = 0;
  logic [31:0] mem_wdata = 0, mem_rdata, rv;
  logic [7:0] pad_in = 0, gpio_filt, seen;
  int checks = 0, errors = 0, lat;
  gpio_irq_filter dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .pad_in(pad_in), .gpio_filt(gpio_filt),
    .irq(irq), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  always #5 mem_clk = ~mem_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge mem_clk);
      #1 seen |= gpio_filt;
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    step(1);
    mem_valid = 0; mem_wstrb = 0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    mem_valid = 1; mem_addr = a; mem_wstrb = 0;
    #1 d = mem_rdata;
    mem_valid = 0;
  endtask
  task automatic wait_filt(input int bitn, output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (gpio_filt[bitn]) begin n = i; break; end
    end
  endtask
  initial begin
    step(3);
    rst_n = 1;
    for (int a = 0; a < 8; a++) begin
      rd(a[3:0], rv);
      chk($sformatf("reset_rd%0d", a), rv, 0);
    end
    chk("reset_irq", irq, 0);
    mem_valid = 1; #1 chk("ready_hi", mem_ready, 1);
    mem_valid = 0; #1 chk("ready_lo", mem_ready, 0);
    chk("rdata_idle", mem_rdata, 0);
    wr(0, 32'hFF, 4'h7);
    rd(0, rv); chk("partial_wr", rv, 0);
    // debounce off: filt three edges after pad change, flag one edge later
    wr(0, 32'h01);
    rd(0, rv); chk("rer_rw", rv, 32'h01);
    pad_in[0] = 1;
    step(2); chk("sync_k1", gpio_filt, 8'h00);
    step(1); chk("sync_k2", gpio_filt, 8'h01); chk("irq_k2", irq, 0);
    step(1); chk("irq_k3", irq, 1);
    rd(2, rv); chk("isfr_rise0", rv, 32'h01);
    wr(2, 32'h01);
    rd(2, rv); chk("isfr_clr0", rv, 0); chk("irq_clr0", irq, 0);
    // falling edge only on pin 7
    pad_in[7] = 1; step(4);
    wr(0, 0); wr(1, 32'h80);
    pad_in[7] = 0; step(4);
    rd(2, rv); chk("isfr_fall7", rv, 32'h80);
    pad_in[7] = 1; step(4);
    rd(2, rv); chk("isfr_rise7_ignored", rv, 32'h80);
    wr(2, 0);
    rd(2, rv); chk("w1c_zero", rv, 32'h80);
    wr(2, 32'h80);
    rd(2, rv); chk("w1c_clear7", rv, 0);
    // set beats simultaneous clear on pin 2
    wr(1, 0); wr(0, 32'h04);
    pad_in[2] = 1; step(3);
    wr(2, 32'h04);
    rd(2, rv); chk("set_wins", rv, 32'h04);
    wr(2, 32'h04);
    rd(2, rv); chk("clr_after", rv, 0);
    // debounce on pin 1 with tick every 4 cycles
    wr(0, 32'h02); wr(3, 3); wr(4, 32'h02);
    rd(3, rv); chk("dbdiv_rw", rv, 3);
    seen = 0;
    pad_in[1] = 1; step(4); pad_in[1] = 0; step(12);
    pad_in[1] = 1; step(8); pad_in[1] = 0; step(12);
    chk("glitch_filt", seen[1], 0);
    rd(2, rv); chk("glitch_flag", rv, 0);
    pad_in[1] = 1;
    wait_filt(1, lat);
    chk("db_lat_window", (lat >= 11 && lat <= 14), 1);
    step(1);
    rd(2, rv); chk("db_flag1", rv, 32'h02);
    // all pins flag, then reset mid-debounce
    wr(4, 0); wr(0, 32'hFF); wr(1, 32'hFF); wr(2, 32'hFF);
    pad_in = 8'h78; step(4);
    rd(2, rv); chk("isfr_all", rv, 32'hFF);
    chk("filt_all", gpio_filt, 8'h78);
    wr(3, 0); wr(4, 32'hFF);
    pad_in = 8'h87; step(2);
    #2 rst_n = 0;
    #1 chk("rst_filt", gpio_filt, 0); chk("rst_irq", irq, 0);
    rd(2, rv); chk("rst_isfr", rv, 0);
    pad_in = 0; step(2);
    rst_n = 1;
    rd(4, rv); chk("rst_dben", rv, 0);
    rd(0, rv); chk("rst_rer", rv, 0);
    wr(4, 32'h01);
    pad_in = 8'h01;
    wait_filt(0, lat);
    chk("db0_latency", lat, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
